display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the four-digit seven-segment display. It owns the shared anode/segment pins and gives each digit a fixed, equal time slot. Each slot starts with a blanking interval to suppress ghosting. Segment patterns are double-buffered: upstream logic writes a full 4-digit pattern through a valid/ready handshake, and the block swaps it into the display only at a frame boundary, so a frame never shows mixed old/new data.

---
 rtl/display_scan_ctrl_if.sv | 8 +
 rtl/display_scan_ctrl.sv | 79 +++++++
 tb/tb_display_scan_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: valid/ready pattern-write channel from upstream logic into the scan controller.
interface display_scan_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit seven-segment scan with per-slot blanking and a
// double-buffered pattern that only swaps in at a frame boundary.
module display_scan_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_ctrl_if.slave  wr,
    input  logic [3:0]          digit_en,
    output logic [3:0]          anode,
    output logic [7:0]          ledx,
    output logic                frame_start
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST      = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    typedef enum logic {BLANK, DRIVE} phase_t;

    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [31:0]   shadow_q, shadow_d, active_q, active_d;
    logic          pending_q, pending_d;
    logic          run_q, wrap, swap, xfer, drive;
    logic [3:0]    anode_q, anode_d;
    logic [7:0]    ledx_q, ledx_d;
    logic          wr_ready_q, frame_start_q;

    // run_q holds the counter at 0 for the first cycle after reset so cycle 0 is cnt=0.
    always_comb begin
        wrap      = run_q && cnt_q == LAST;
        swap      = wrap && dig_q == 2'd3 && pending_q;
        xfer      = wr.wr_valid && wr_ready_q;
        cnt_d     = (!run_q || wrap) ? '0 : cnt_q + 1'b1;
        dig_d     = wrap ? dig_q + 2'd1 : dig_q;
        phase_d   = wrap ? BLANK : (cnt_d == BLANK_END ? DRIVE : phase_q);
        shadow_d  = xfer ? wr.wr_data : shadow_q;
        active_d  = swap ? shadow_q : active_q;
        pending_d = xfer || (pending_q && !swap);
        drive     = phase_d == DRIVE && digit_en[dig_d];
        anode_d   = drive ? ~(4'b0001 << dig_d) : 4'hF;
        ledx_d    = drive ? active_d[{dig_d, 3'b000} +: 8] : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q       <= BLANK;
            cnt_q         <= '0;
            dig_q         <= 2'd0;
            shadow_q      <= 32'hFFFF_FFFF;
            active_q      <= 32'hFFFF_FFFF;
            pending_q     <= 1'b0;
            run_q         <= 1'b0;
            anode_q       <= 4'hF;
            ledx_q        <= 8'hFF;
            wr_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            run_q         <= 1'b1;
            anode_q       <= anode_d;
            ledx_q        <= ledx_d;
            wr_ready_q    <= run_q && !pending_d;
            frame_start_q <= cnt_d == '0 && dig_d == 2'd0;
        end
    end

    assign wr.wr_ready  = wr_ready_q;
    assign anode        = anode_q;
    assign ledx         = ledx_q;
    assign frame_start  = frame_start_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: cycle-level reference model pushes expected outputs each edge;
// a negedge checker pops and compares them against the DUT.
module tb_display_scan_ctrl;
    localparam int T = 8;
    localparam int B = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] lx;
        logic       rdy;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  digit_en;
    logic [3:0]  anode;
    logic [7:0]  ledx;
    logic        frame_start;
    int          tests = 0;
    int          fails = 0;
    exp_t        q[$];

    display_scan_ctrl_if wr_if();

    display_scan_ctrl #(.TICK_DIV(T), .BLANK_CYCLES(B)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr_if.slave),
        .digit_en    (digit_en),
        .anode       (anode),
        .ledx        (ledx),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model in terms of the cycle index k since reset release.
    int          k = 0;
    logic [31:0] m_act, m_sh;
    logic        m_pend, m_rdy, m_started;

    always @(posedge clk) begin
        exp_t e;
        int   pos, slot;
        if (!rst_n) begin
            k = 0; m_act = '1; m_sh = '1; m_pend = 0; m_rdy = 0; m_started = 0;
            e = '{an: 4'hF, lx: 8'hFF, rdy: 1'b0, fs: 1'b0};
        end else begin
            if (k > 0 && k % (4*T) == 0 && m_pend) begin
                m_act  = m_sh;
                m_pend = 0;
            end
            if (wr_if.wr_valid && m_rdy) begin
                m_sh   = wr_if.wr_data;
                m_pend = 1;
            end
            m_rdy     = m_started && !m_pend;
            m_started = 1;
            pos  = k % T;
            slot = (k / T) % 4;
            if (pos >= B && digit_en[slot]) begin
                e.an = 4'hF & ~(4'b0001 << slot);
                e.lx = 8'((m_act >> (8*slot)) & 32'hFF);
            end else begin
                e.an = 4'hF;
                e.lx = 8'hFF;
            end
            e.rdy = m_rdy;
            e.fs  = (k % (4*T) == 0);
            k++;
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("anode", 32'(anode), 32'(e.an));
            check("ledx", 32'(ledx), 32'(e.lx));
            check("wr_ready", 32'(wr_if.wr_ready), 32'(e.rdy));
            check("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    // Upstream master: hold valid/data until a transfer, bounded by budget cycles.
    task automatic send(input logic [31:0] d, input int budget);
        int n = 0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        while (!wr_if.wr_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("xfer_timeout", 32'(n < budget), 32'd1);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while (!frame_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        digit_en       = 4'hF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(32'h0011_2233, 40);
        repeat (40) @(negedge clk);
        send(32'h4455_6677, 40);
        send(32'hAAAA_AAAA, 100);
        repeat (80) @(negedge clk);
        digit_en = 4'b0101;
        repeat (64) @(negedge clk);
        digit_en = 4'hF;
        repeat (16) @(negedge clk);
        send(32'h8899_CCDD, 80);
        repeat (20) @(negedge clk);
        digit_en = 4'b1010;
        repeat (50) @(negedge clk);
        digit_en = 4'hF;
        wait_frame(80);
        send(32'h1234_5678, 40);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
